// File: rtl/dm_responder.sv
// dm_responder: data-memory responder for the pipeline MEM-stage port.
// Holds 2**ADDR_W 32-bit words with byte-lane writes and registered read data.
// A programmable wait-state FSM adds WAIT_CYCLES cycles before the access.
// Completion is reported by a one-cycle ready pulse, with err on the same cycle.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous reset, active low
//   cs     - request valid / chip select
//   oe     - read request
//   web    - byte write enables, active low (lane i = bits 8i+7:8i)
//   addr   - byte address; word index = addr[ADDR_W+1:2]
//   wdata  - lane-aligned write data
//   rdata  - registered read data, held until the next completed read
//   ready  - one-cycle completion pulse
//   err    - one-cycle out-of-range pulse, coincident with ready
//   busy   - high while waiting; requests are dropped
module dm_responder #(
    parameter int ADDR_W      = 14,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        oe,
    input  logic [3:0]  web,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);
    localparam int         DEPTH    = 1 << ADDR_W;
    localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic              wr;
        logic              rd;
        logic              oor;
        logic [ADDR_W-1:0] idx;
        logic [3:0]        web;
        logic [31:0]       wdata;
    } req_t;

    logic [31:0] mem [DEPTH];

    state_t     state, state_nxt;
    logic [3:0] cnt;
    req_t       cur, lat, acc;
    logic       accept, do_access;

    always_comb begin
        cur.wr    = (web != 4'hF);            // any write lane wins over oe
        cur.rd    = (web == 4'hF) && oe;
        cur.oor   = |addr[31:ADDR_W+2];
        cur.idx   = addr[ADDR_W+1:2];
        cur.web   = web;
        cur.wdata = wdata;

        accept = cs && (cur.wr || cur.rd) && (state != S_WAIT);

        // In WAIT the access uses the latched request; otherwise with no
        // wait states the live request is accessed on its accept edge.
        if (state == S_WAIT) begin
            acc       = lat;
            do_access = (cnt == 4'd0);
        end else begin
            acc       = cur;
            do_access = accept && NO_WAIT;
        end

        case (state)
            S_WAIT:  state_nxt = (cnt == 4'd0) ? S_RESP : S_WAIT;
            default: state_nxt = accept ? (NO_WAIT ? S_RESP : S_WAIT) : S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            rdata <= 32'd0;
            ready <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            ready <= (state_nxt == S_RESP);
            err   <= (state_nxt == S_RESP) && acc.oor;
            busy  <= (state_nxt == S_WAIT);
            if (state == S_WAIT) begin
                if (cnt != 4'd0) cnt <= cnt - 4'd1;
            end else if (accept) begin
                cnt <= CNT_INIT;
            end
            if (do_access && acc.rd)
                rdata <= acc.oor ? 32'd0 : mem[acc.idx];
        end
    end

    // Request latch has no reset: a reset returns to IDLE, so a stale
    // latched request is never accessed.
    always_ff @(posedge clk) begin
        if (accept) lat <= cur;
    end

    // Array is not cleared by reset; a reset edge blocks a pending write.
    always_ff @(posedge clk) begin
        if (rst && do_access && acc.wr && !acc.oor) begin
            for (int i = 0; i < 4; i++) begin
                if (!acc.web[i]) mem[acc.idx][8*i +: 8] <= acc.wdata[8*i +: 8];
            end
        end
    end

endmodule
